// File: rtl/id_arb_ctrl_pkg.sv
// id_arb_ctrl_pkg: controller state encoding and character class constants
package id_arb_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

    localparam logic [7:0] NUL   = 8'h00;
    localparam logic [7:0] UC_LO = 8'h41;
    localparam logic [7:0] UC_HI = 8'h5A;
    localparam logic [7:0] LC_LO = 8'h61;
    localparam logic [7:0] LC_HI = 8'h7A;
    localparam logic [7:0] DG_LO = 8'h30;
    localparam logic [7:0] DG_HI = 8'h39;

    function automatic logic is_letter(input logic [7:0] c);
        return (c >= UC_LO && c <= UC_HI) || (c >= LC_LO && c <= LC_HI);
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return c >= DG_LO && c <= DG_HI;
    endfunction

endpackage

// File: rtl/id_match.sv
// id_match: identifier recognizer flagging digits that continue a letter-started run
module id_match
    import id_arb_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] char,
    output logic       match
);

    logic alpha_q, alpha_d;

    assign match = alpha_q && is_digit(char);

    // letters open a run, digits keep it, anything else (or end of string) closes it
    always_comb begin
        alpha_d = clr ? 1'b0 : en ? (is_letter(char) ? 1'b1 : (is_digit(char) ? alpha_q : 1'b0)) : alpha_q;
    end

    // alpha register
    always_ff @(posedge clk) begin
        alpha_q <= reset ? 1'b0 : alpha_d;
    end

endmodule

// File: rtl/id_arb_ctrl.sv
// id_arb_ctrl: round-robin arbiter of two character sources into one identifier recognizer
module id_arb_ctrl
    import id_arb_ctrl_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s0_valid,
    input  logic [7:0]       s0_char,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [7:0]       s1_char,
    output logic             s1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_src,
    output logic [CNT_W-1:0] res_len,
    output logic [CNT_W-1:0] res_hits,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ONE = 1;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d, rr_q, rr_d, res_src_q, res_src_d;
    logic [CNT_W-1:0] len_q, len_d, hits_q, hits_d;
    logic [CNT_W-1:0] res_len_q, res_len_d, res_hits_q, res_hits_d;
    logic [7:0]       cur_char;
    logic             xfer, is_nul, match;

    assign cur_char  = gnt_q ? s1_char : s0_char;
    assign xfer      = state_q == RUN && (gnt_q ? s1_valid : s0_valid);
    assign is_nul    = cur_char == NUL;
    assign s0_ready  = state_q == RUN && !gnt_q;
    assign s1_ready  = state_q == RUN && gnt_q;
    assign res_valid = state_q == REPORT;
    assign busy      = state_q != IDLE;
    assign res_src   = res_src_q;
    assign res_len   = res_len_q;
    assign res_hits  = res_hits_q;

    id_match u_match (
        .clk   (clk),
        .reset (reset),
        .en    (xfer && !is_nul),
        .clr   (xfer && is_nul),
        .char  (cur_char),
        .match (match)
    );

    // grant selection, per-string counting and result capture
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        len_d      = len_q;
        hits_d     = hits_q;
        res_src_d  = res_src_q;
        res_len_d  = res_len_q;
        res_hits_d = res_hits_q;
        case (state_q)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    gnt_d   = (s0_valid && s1_valid) ? rr_q : !s0_valid;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer && is_nul) begin
                    res_src_d  = gnt_q;
                    res_len_d  = len_q;
                    res_hits_d = hits_q;
                    len_d      = '0;
                    hits_d     = '0;
                    state_d    = REPORT;
                end else if (xfer) begin
                    len_d  = &len_q ? len_q : len_q + ONE;
                    hits_d = (match && !(&hits_q)) ? hits_q + ONE : hits_q;
                end
            end
            REPORT: begin
                if (res_ready) begin
                    rr_d    = !gnt_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state, pointer, counter and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            rr_q       <= 1'b0;
            len_q      <= '0;
            hits_q     <= '0;
            res_src_q  <= 1'b0;
            res_len_q  <= '0;
            res_hits_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            len_q      <= len_d;
            hits_q     <= hits_d;
            res_src_q  <= res_src_d;
            res_len_q  <= res_len_d;
            res_hits_q <= res_hits_d;
        end
    end

endmodule

// File: tb/tb_id_arb_ctrl.sv
// tb_id_arb_ctrl: randomized and directed checks of id_arb_ctrl against a string-level model
module tb_id_arb_ctrl;

    logic       clk = 1'b0, reset = 1'b1, s0_valid = 1'b0, s1_valid = 1'b0, res_ready = 1'b0;
    logic [7:0] s0_char = 8'h00, s1_char = 8'h00;
    logic       s0_ready, s1_ready, res_valid, res_src, busy;
    logic [7:0] res_len, res_hits;

    int         checks = 0, failures = 0;
    string      str0[$], str1[$];
    logic       exp_src[$], obs_src[$];
    logic [7:0] exp_len[$], exp_hits[$], obs_len[$], obs_hits[$];
    int         rep_len[$];
    int         viol_ready, viol_hold, rr_model;

    id_arb_ctrl #(.CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .s0_valid  (s0_valid),
        .s0_char   (s0_char),
        .s0_ready  (s0_ready),
        .s1_valid  (s1_valid),
        .s1_char   (s1_char),
        .s1_ready  (s1_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_src   (res_src),
        .res_len   (res_len),
        .res_hits  (res_hits),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // hits of a string: digits preceded by an unbroken letter/digit run that started with a letter
    function automatic logic [7:0] model_hits(input string s);
        int h = 0;
        bit a = 0, lt, dg;
        logic [7:0] c;
        for (int k = 0; k < s.len(); k++) begin
            c = s[k];
            lt = (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
            dg = c >= "0" && c <= "9";
            if (dg && a) h++;
            a = lt ? 1'b1 : (dg ? a : 1'b0);
        end
        return 8'(h > 255 ? 255 : h);
    endfunction

    // string-level arbitration: both pending -> rr pick, then rr moves to the other source
    task automatic build_expected();
        int i0 = 0, i1 = 0, p;
        string s;
        exp_src.delete(); exp_len.delete(); exp_hits.delete();
        while (i0 < str0.size() || i1 < str1.size()) begin
            p = (i0 < str0.size() && i1 < str1.size()) ? rr_model : (i0 < str0.size() ? 0 : 1);
            if (p == 1) s = str1[i1++];
            else s = str0[i0++];
            exp_src.push_back(p[0]);
            exp_len.push_back(8'(s.len() > 255 ? 255 : s.len()));
            exp_hits.push_back(model_hits(s));
            rr_model = 1 - p;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0; res_ready = 1'b0;
        rr_model = 0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // drives both sources from str0/str1 and records every accepted result
    task automatic run_engine(input int stall_min, input int stall_max);
        logic [7:0] b0[$], b1[$];
        int stall, held = 0, rc = 0;
        bit pend = 0;
        logic [16:0] prev = '0;
        foreach (str0[i]) begin
            for (int k = 0; k < str0[i].len(); k++) b0.push_back(str0[i][k]);
            b0.push_back(8'h00);
        end
        foreach (str1[i]) begin
            for (int k = 0; k < str1[i].len(); k++) b1.push_back(str1[i][k]);
            b1.push_back(8'h00);
        end
        obs_src.delete(); obs_len.delete(); obs_hits.delete(); rep_len.delete();
        viol_ready = 0; viol_hold = 0;
        stall = $urandom_range(stall_max, stall_min);
        for (int cyc = 0; cyc < 20000 && obs_src.size() < exp_src.size(); cyc++) begin
            s0_valid = b0.size() > 0;
            s0_char  = s0_valid ? b0[0] : 8'h00;
            s1_valid = b1.size() > 0;
            s1_char  = s1_valid ? b1[0] : 8'h00;
            res_ready = res_valid ? (held >= stall) : 1'($urandom_range(1, 0));
            @(negedge clk);
            if (s0_ready && s1_ready) viol_ready++;
            if (res_valid) begin
                rc++;
                if (s0_ready || s1_ready) viol_ready++;
                if (pend && {res_src, res_len, res_hits} !== prev) viol_hold++;
                if (res_ready) begin
                    obs_src.push_back(res_src); obs_len.push_back(res_len); obs_hits.push_back(res_hits);
                    rep_len.push_back(rc);
                    rc = 0; held = 0;
                    stall = $urandom_range(stall_max, stall_min);
                end else held++;
            end
            pend = res_valid && !res_ready;
            prev = {res_src, res_len, res_hits};
            if (s0_valid && s0_ready) void'(b0.pop_front());
            if (s1_valid && s1_ready) void'(b1.pop_front());
            @(posedge clk); #1;
        end
        s0_valid = 1'b0; s1_valid = 1'b0; res_ready = 1'b0;
        str0.delete(); str1.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({busy, res_valid, s0_ready, s1_ready, res_src, res_len, res_hits} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {busy, res_valid, s0_ready, s1_ready, res_src, res_len, res_hits});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        str0 = '{"ab12"};
        build_expected();
        run_engine(0, 0);
        checks++;
        if (obs_src.size() !== 1) begin
            failures++; $display("FAIL basic_count got=%0d exp=1", obs_src.size());
        end else begin
            checks++;
            if ({obs_src[0], obs_len[0], obs_hits[0]} !== {1'b0, 8'd4, 8'd2}) begin
                failures++; $display("FAIL basic_result got=%0d/%0d/%0d exp=0/4/2", obs_src[0], obs_len[0], obs_hits[0]);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({res_valid, busy, res_src, res_len, res_hits} !== {1'b0, 1'b0, 1'b0, 8'd4, 8'd2}) begin
            failures++; $display("FAIL basic_hold got=%h exp=%h", {res_valid, busy, res_src, res_len, res_hits}, {3'b000, 8'd4, 8'd2});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        do_reset();
        str0 = '{"x1"};
        str1 = '{"9z-3"};
        build_expected();
        run_engine(0, 2);
        checks++;
        if (obs_src.size() !== 2) begin
            failures++; $display("FAIL arb_count got=%0d exp=2", obs_src.size());
        end else begin
            checks++;
            if ({obs_src[0], obs_len[0], obs_hits[0], obs_src[1], obs_len[1], obs_hits[1]} !==
                {1'b0, 8'd2, 8'd1, 1'b1, 8'd4, 8'd0}) begin
                failures++;
                $display("FAIL arb_order got=%0d/%0d/%0d,%0d/%0d/%0d exp=0/2/1,1/4/0",
                         obs_src[0], obs_len[0], obs_hits[0], obs_src[1], obs_len[1], obs_hits[1]);
            end
        end
        checks++;
        if (viol_ready !== 0) begin
            failures++; $display("FAIL arb_ready_exclusive got=%0d exp=0", viol_ready);
        end
    endtask

    task automatic test_empty();
        str1 = '{""};
        build_expected();
        run_engine(0, 0);
        checks++;
        if (obs_src.size() !== 1) begin
            failures++; $display("FAIL empty_count got=%0d exp=1", obs_src.size());
        end else begin
            checks++;
            if ({obs_src[0], obs_len[0], obs_hits[0]} !== {1'b1, 8'd0, 8'd0}) begin
                failures++; $display("FAIL empty_result got=%0d/%0d/%0d exp=1/0/0", obs_src[0], obs_len[0], obs_hits[0]);
            end
        end
    endtask

    task automatic test_saturation();
        string s = "a";
        repeat (299) s = {s, "1"};
        str0 = '{s};
        build_expected();
        run_engine(0, 0);
        checks++;
        if (obs_src.size() !== 1) begin
            failures++; $display("FAIL sat_count got=%0d exp=1", obs_src.size());
        end else begin
            checks++;
            if ({obs_src[0], obs_len[0], obs_hits[0]} !== {1'b0, 8'd255, 8'd255}) begin
                failures++; $display("FAIL sat_result got=%0d/%0d/%0d exp=0/255/255", obs_src[0], obs_len[0], obs_hits[0]);
            end
        end
    endtask

    task automatic test_reset_abort();
        int seen = 0;
        logic [7:0] chars[4];
        chars = '{"a", "b", "c", "1"};
        s0_valid = 1'b1;
        s0_char  = chars[0];
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            s0_char = chars[k];
            @(posedge clk); #1;
        end
        s0_char = chars[3];
        reset = 1'b1;
        rr_model = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        s0_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (res_valid || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++; $display("FAIL abort_no_report got=%0d exp=0", seen);
        end
        checks++;
        if ({res_src, res_len, res_hits} !== 17'd0) begin
            failures++; $display("FAIL abort_cleared got=%h exp=0", {res_src, res_len, res_hits});
        end
        @(posedge clk); #1;
        str0 = '{"q7"};
        build_expected();
        run_engine(0, 0);
        checks++;
        if (obs_src.size() !== 1) begin
            failures++; $display("FAIL abort_count got=%0d exp=1", obs_src.size());
        end else begin
            checks++;
            if ({obs_src[0], obs_len[0], obs_hits[0]} !== {1'b0, 8'd2, 8'd1}) begin
                failures++; $display("FAIL abort_next got=%0d/%0d/%0d exp=0/2/1", obs_src[0], obs_len[0], obs_hits[0]);
            end
        end
    endtask

    task automatic test_report_stall();
        str0 = '{"id3", "k"};
        str1 = '{"z9"};
        build_expected();
        run_engine(5, 5);
        checks++;
        if (obs_src.size() !== exp_src.size()) begin
            failures++; $display("FAIL stall_count got=%0d exp=%0d", obs_src.size(), exp_src.size());
        end
        foreach (rep_len[i]) begin
            checks++;
            if (rep_len[i] !== 6) begin
                failures++; $display("FAIL stall_report_cycles idx=%0d got=%0d exp=6", i, rep_len[i]);
            end
        end
        checks++;
        if ({viol_hold, viol_ready} !== 64'd0) begin
            failures++; $display("FAIL stall_stable got=hold%0d/ready%0d exp=0/0", viol_hold, viol_ready);
        end
    endtask

    task automatic test_back_to_back();
        str0 = '{"a1", "b22", "", "9"};
        build_expected();
        run_engine(0, 0);
        checks++;
        if (obs_src.size() !== exp_src.size()) begin
            failures++; $display("FAIL b2b_count got=%0d exp=%0d", obs_src.size(), exp_src.size());
        end
        for (int i = 0; i < obs_src.size() && i < exp_src.size(); i++) begin
            checks++;
            if ({obs_src[i], obs_len[i], obs_hits[i], rep_len[i]} !== {exp_src[i], exp_len[i], exp_hits[i], 32'd1}) begin
                failures++;
                $display("FAIL b2b_result idx=%0d got=%0d/%0d/%0d cyc%0d exp=%0d/%0d/%0d cyc1",
                         i, obs_src[i], obs_len[i], obs_hits[i], rep_len[i], exp_src[i], exp_len[i], exp_hits[i]);
            end
        end
    endtask

    task automatic test_random();
        string pool = "aZqm0579_-. ";
        string s;
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(4, 0)) begin
                s = "";
                repeat ($urandom_range(8, 0)) begin
                    int idx = $urandom_range(pool.len() - 1, 0);
                    s = {s, pool.substr(idx, idx)};
                end
                str0.push_back(s);
            end
            repeat ($urandom_range(4, 0)) begin
                s = "";
                repeat ($urandom_range(8, 0)) begin
                    int idx = $urandom_range(pool.len() - 1, 0);
                    s = {s, pool.substr(idx, idx)};
                end
                str1.push_back(s);
            end
            build_expected();
            run_engine(0, 3);
            checks++;
            if (obs_src.size() !== exp_src.size()) begin
                failures++; $display("FAIL rand_count round=%0d got=%0d exp=%0d", r, obs_src.size(), exp_src.size());
            end
            for (int i = 0; i < obs_src.size() && i < exp_src.size(); i++) begin
                checks++;
                if ({obs_src[i], obs_len[i], obs_hits[i]} !== {exp_src[i], exp_len[i], exp_hits[i]}) begin
                    failures++;
                    $display("FAIL rand_result round=%0d idx=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                             r, i, obs_src[i], obs_len[i], obs_hits[i], exp_src[i], exp_len[i], exp_hits[i]);
                end
            end
            checks++;
            if ({viol_hold, viol_ready} !== 64'd0) begin
                failures++; $display("FAIL rand_protocol round=%0d got=hold%0d/ready%0d exp=0/0", r, viol_hold, viol_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arbitration();
        test_empty();
        test_saturation();
        test_reset_abort();
        test_report_stall();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
